fact_seq_ctrl: RTL and testbench

//  Multi-cycle factorial engine: one shared multiplier, stepped by an FSM, one multiply per cycle.

---
 rtl/fact_pkg.sv | 18 +
 rtl/fact_mul_step.sv | 37 +++
 rtl/fact_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_fact_seq_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fact_pkg.sv
// Shared types and default sizes for the sequential factorial engine.
// Optional overflow reporting is controlled by the FACT_OVF_EN macro.
package fact_pkg;

  // Default operand width; n ranges over 0 .. 2^FACT_N_W-1
  localparam int FACT_N_W   = 4;

  // Default result width; results are kept modulo 2^FACT_OUT_W
  localparam int FACT_OUT_W = 32;

  // Engine control states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } fact_state_t;

endpackage

// File: rtl/fact_mul_step.sv
// One multiply step of the factorial loop: prod = acc * i, truncated to OUT_W.
// With FACT_OVF_EN defined the full product is formed so that a nonzero
// upper slice can be flagged; without it only the low OUT_W bits are built.
module fact_mul_step
  import fact_pkg::*;
#(
  parameter int N_W   = FACT_N_W,
  parameter int OUT_W = FACT_OUT_W
) (
  input  logic [OUT_W-1:0] i_acc,
  input  logic [N_W-1:0]   i_mul,
  output logic [OUT_W-1:0] o_prod
`ifdef FACT_OVF_EN
  ,
  output logic             o_hi_nonzero
`endif
);

`ifdef FACT_OVF_EN
  localparam int P_W = OUT_W + N_W;

  logic [P_W-1:0] w_prod_full;

  // Full-width product, split into the kept result and the overflow flag
  always_comb begin
    w_prod_full  = P_W'(i_acc) * P_W'(i_mul);
    o_prod       = w_prod_full[OUT_W-1:0];
    o_hi_nonzero = |w_prod_full[P_W-1:OUT_W];
  end
`else
  // Low bits of a product depend only on low bits of the operands
  always_comb begin
    o_prod = i_acc * OUT_W'(i_mul);
  end
`endif

endmodule

// File: rtl/fact_seq_ctrl.sv
// Multi-cycle factorial engine with valid/ready request and result channels.
// A single shared multiplier (fact_mul_step) is stepped once per cycle by the
// FSM below. Define FACT_OVF_EN to add the sticky o_ovf result flag.
module fact_seq_ctrl
  import fact_pkg::*;
#(
  parameter int N_W   = FACT_N_W,
  parameter int OUT_W = FACT_OUT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start_valid,
  output logic             o_start_ready,
  input  logic [N_W-1:0]   i_num,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [OUT_W-1:0] o_fact,
  output logic             o_busy
`ifdef FACT_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  fact_state_t      r_state;
  logic [N_W-1:0]   r_n;
  logic [N_W-1:0]   r_i;
  logic [OUT_W-1:0] r_acc;
  logic [OUT_W-1:0] r_fact;
  logic             r_res_valid;
  logic             r_busy;
  logic             r_start_ready;
  logic [OUT_W-1:0] w_prod;
`ifdef FACT_OVF_EN
  logic             r_ovf;
  logic             w_hi_nonzero;
`endif

  fact_mul_step #(
    .N_W   (N_W),
    .OUT_W (OUT_W)
  ) u_mul_step (
    .i_acc        (r_acc),
    .i_mul        (r_i),
    .o_prod       (w_prod)
`ifdef FACT_OVF_EN
    ,
    .o_hi_nonzero (w_hi_nonzero)
`endif
  );

  // Control FSM plus all datapath and output registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_n           <= {N_W{1'b0}};
      r_i           <= {N_W{1'b0}};
      r_acc         <= {OUT_W{1'b0}};
      r_fact        <= {OUT_W{1'b0}};
      r_res_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_start_ready <= 1'b1;
`ifdef FACT_OVF_EN
      r_ovf         <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start_valid) begin
            r_n           <= i_num;
            r_acc         <= OUT_W'(1);
            r_busy        <= 1'b1;
            r_start_ready <= 1'b0;
`ifdef FACT_OVF_EN
            r_ovf         <= 1'b0;
`endif
            if (i_num <= N_W'(1)) begin
              // 0! and 1! need no multiply: present 1 right away
              r_state     <= DONE;
              r_fact      <= OUT_W'(1);
              r_res_valid <= 1'b1;
            end else begin
              r_state <= CALC;
              r_i     <= N_W'(2);
            end
          end
        end

        CALC: begin
          r_acc <= w_prod;
`ifdef FACT_OVF_EN
          r_ovf <= r_ovf | w_hi_nonzero;
`endif
          // Exit on the last factor so r_i never has to pass n (no wrap)
          if (r_i == r_n) begin
            r_state     <= DONE;
            r_fact      <= w_prod;
            r_res_valid <= 1'b1;
          end else begin
            r_i <= r_i + N_W'(1);
          end
        end

        DONE: begin
          // Result held until consumed; start_ready only rises afterwards
          if (i_res_ready) begin
            r_state       <= IDLE;
            r_res_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
          end
        end

        default: begin
          // Unreachable encoding: recover to a clean idle state
          r_state       <= IDLE;
          r_res_valid   <= 1'b0;
          r_busy        <= 1'b0;
          r_start_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_start_ready = r_start_ready;
  assign o_res_valid   = r_res_valid;
  assign o_fact        = r_fact;
  assign o_busy        = r_busy;
`ifdef FACT_OVF_EN
  assign o_ovf         = r_ovf;
`endif

endmodule

// File: tb/tb_fact_seq_ctrl.sv
// Directed self-checking bench for fact_seq_ctrl (default N_W=4, OUT_W=32).
// Overflow checks are compiled in only when FACT_OVF_EN is defined.
module tb_fact_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid;
  logic        res_ready;
  logic [3:0]  num;
  logic        start_ready;
  logic        res_valid;
  logic        busy;
  logic [31:0] fact;
`ifdef FACT_OVF_EN
  logic        ovf;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fact_seq_ctrl dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start_valid (start_valid),
    .o_start_ready (start_ready),
    .i_num         (num),
    .o_res_valid   (res_valid),
    .i_res_ready   (res_ready),
    .o_fact        (fact),
    .o_busy        (busy)
`ifdef FACT_OVF_EN
    ,
    .o_ovf         (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_ovf(input string tag, input logic exp);
`ifdef FACT_OVF_EN
    chk(tag, 32'(ovf), 32'(exp));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request for n and check result, latency, busy and return to idle.
  // hold > 0 keeps res_ready low for that many cycles in DONE while poking inputs.
  task automatic run(input logic [3:0] n, input logic [31:0] exp_fact,
                     input int exp_lat, input logic exp_ovf, input int hold);
    int lat = 0;
    int nb  = 0;
    chk("start_ready_before_req", 32'(start_ready), 32'd1);
    num         = n;
    start_valid = 1'b1;
    res_ready   = (hold == 0);
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (res_valid) begin
        lat = c;
        break;
      end
      if (!busy) nb++;
      start_valid = c[0];
      num         = ~n;
    end
    start_valid = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("fact", fact, exp_fact);
    chk("busy_in_done", 32'(busy), 32'd1);
    chk("busy_gaps_in_calc", 32'(nb), 32'd0);
    chk("start_ready_in_done", 32'(start_ready), 32'd0);
    chk_ovf("ovf", exp_ovf);
    if (hold > 0) begin
      for (int h = 1; h <= hold; h++) begin
        start_valid = h[0];
        num         = h[3:0];
        tick();
        chk("hold_fact", fact, exp_fact);
        chk("hold_res_valid", 32'(res_valid), 32'd1);
        chk("hold_start_ready", 32'(start_ready), 32'd0);
      end
      res_ready   = 1'b1;
      start_valid = 1'b1;
      num         = 4'd2;
    end
    tick();
    start_valid = 1'b0;
    chk("res_valid_after_hs", 32'(res_valid), 32'd0);
    chk("start_ready_after_hs", 32'(start_ready), 32'd1);
    chk("busy_after_hs", 32'(busy), 32'd0);
    chk("fact_held_in_idle", fact, exp_fact);
    chk_ovf("ovf_held_in_idle", exp_ovf);
    res_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    num         = 4'd0;
    tick();
    tick();
    chk("rst_start_ready", 32'(start_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_fact", fact, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_ovf("rst_ovf", 1'b0);
    rst_n = 1'b1;
    tick();

    run(4'd0,  32'd1,          1,  1'b0, 0);
    run(4'd1,  32'd1,          1,  1'b0, 0);
    run(4'd5,  32'd120,        5,  1'b0, 0);
    run(4'd12, 32'd479001600,  12, 1'b0, 0);
    run(4'd13, 32'd1932053504, 13, 1'b1, 0);
    run(4'd15, 32'd2004310016, 15, 1'b1, 0);
    run(4'd6,  32'd720,        6,  1'b0, 10);
    run(4'd3,  32'd6,          3,  1'b0, 0);

    // Abort a 9! computation in its fourth CALC cycle
    num         = 4'd9;
    start_valid = 1'b1;
    res_ready   = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("busy_before_abort", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("abort_start_ready", 32'(start_ready), 32'd1);
    chk("abort_res_valid", 32'(res_valid), 32'd0);
    chk("abort_fact", fact, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk_ovf("abort_ovf", 1'b0);
    rst_n     = 1'b1;
    res_ready = 1'b0;
    tick();
    run(4'd3, 32'd6, 3, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
